// File: rtl/pe_acc_pkg.sv
// Shared constants and FSM state type for the pe_acc accumulation stage.
// Optional saturation is selected elsewhere by defining PE_ACC_SAT_EN.
package pe_acc_pkg;

  localparam int unsigned LanesDef = 16;
  localparam int unsigned ProdWDef = 20;
  localparam int unsigned AccWDef  = 32;
  localparam int unsigned LenWDef  = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StOut  = 2'd2
  } state_e;

endpackage

// File: rtl/pe_acc_if.sv
// Product-in / result-out handshake bundle between the multiplier array, pe_acc and write-back.
interface pe_acc_if
  import pe_acc_pkg::*;
#(
  parameter int unsigned LANES  = LanesDef,
  parameter int unsigned PROD_W = ProdWDef,
  parameter int unsigned ACC_W  = AccWDef
) ();

  logic                    in_vld;
  logic                    in_rdy;
  logic [LANES*PROD_W-1:0] mul_out_dat;
  logic                    out_vld;
  logic                    out_rdy;
  logic [LANES*ACC_W-1:0]  acc_out_dat;

  modport master (
    output in_vld, mul_out_dat, out_rdy,
    input  in_rdy, out_vld, acc_out_dat
  );

  modport slave (
    input  in_vld, mul_out_dat, out_rdy,
    output in_rdy, out_vld, acc_out_dat
  );

endinterface

// File: rtl/pe_acc_lane.sv
// One accumulator lane: sign-extends a product, loads it on the first beat, adds afterwards.
// With PE_ACC_SAT_EN defined the add saturates and a sticky overflow flag is kept.
module pe_acc_lane
  import pe_acc_pkg::*;
#(
  parameter int unsigned PROD_W = ProdWDef,
  parameter int unsigned ACC_W  = AccWDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_i,
  input  logic              first_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d, ext;

  assign ext   = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign acc_o = acc_q;

`ifdef PE_ACC_SAT_EN
  localparam logic [ACC_W-1:0] MaxVal = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MinVal = {1'b1, {(ACC_W-1){1'b0}}};

  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   wide;

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    // One guard bit: top two bits differing means the signed sum left the ACC_W range.
    wide  = {acc_q[ACC_W-1], acc_q} + {ext[ACC_W-1], ext};
    if (beat_i) begin
      if (first_i) begin
        acc_d = ext;
        ovf_d = 1'b0;
      end else if (wide[ACC_W:ACC_W-1] == 2'b01) begin
        acc_d = MaxVal;
        ovf_d = 1'b1;
      end else if (wide[ACC_W:ACC_W-1] == 2'b10) begin
        acc_d = MinVal;
        ovf_d = 1'b1;
      end else begin
        acc_d = wide[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  always_comb begin
    acc_d = acc_q;
    if (beat_i) begin
      acc_d = first_i ? ext : acc_q + ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/pe_acc.sv
// Accumulation stage behind the PE multiplier array: sums each lane over cfg_len beats.
// Define PE_ACC_SAT_EN for saturating lanes with sticky per-lane overflow flags.
module pe_acc
  import pe_acc_pkg::*;
#(
  parameter int unsigned LANES  = LanesDef,
  parameter int unsigned PROD_W = ProdWDef,
  parameter int unsigned ACC_W  = AccWDef,
  parameter int unsigned LEN_W  = LenWDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  pe_acc_if.slave          bus,
  output logic             busy,
  output logic [LANES-1:0] ovf
);

  localparam logic [LEN_W:0] CntOne = {{LEN_W{1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [LEN_W:0]         cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic                   beat;
  logic [LANES*ACC_W-1:0] acc_flat;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    beat        = 1'b0;
    bus.in_rdy  = 1'b0;
    bus.out_vld = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAcc;
          // Extra MSB turns cfg_len == 0 into a full 2^LEN_W beat job.
          cnt_d   = {(cfg_len == '0), cfg_len};
          first_d = 1'b1;
        end
      end
      StAcc: begin
        bus.in_rdy = 1'b1;
        if (bus.in_vld) begin
          beat    = 1'b1;
          first_d = 1'b0;
          cnt_d   = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        bus.out_vld = 1'b1;
        if (bus.out_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign busy            = (state_q != StIdle);
  assign bus.acc_out_dat = acc_flat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_acc_lane #(
      .PROD_W(PROD_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .beat_i (beat),
      .first_i(first_q),
      .prod_i (bus.mul_out_dat[i*PROD_W +: PROD_W]),
      .acc_o  (acc_flat[i*ACC_W +: ACC_W]),
      .ovf_o  (ovf[i])
    );
  end

endmodule
